// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver.
//   - uart_state_e : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   - PAR_*        : parity mode codes for the PARITY parameter
//   - parity_bit() : parity bit for the low nbits of a data byte
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Odd mode: bit that makes the total count of ones odd.
    // Even mode: bit that makes the total count of ones even.
    function automatic logic parity_bit(input logic [7:0]  data,
                                        input int unsigned nbits,
                                        input int unsigned mode);
        logic x;
        x = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) begin
                x = x ^ data[i];
            end
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period timer. Counts 0..DIVISOR-1 and wraps.
//   Ports:
//     clk         in  system clock
//     resetn      in  asynchronous, active-high reset
//     i_clear     in  hold the counter at 0 (so a bit period starts aligned)
//     o_tick      out high on the last cycle of each bit period
//     o_pre_tick  out high on the cycle before o_tick (lets the owner register
//                     a pulse that lands exactly on the tick cycle)
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 54
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIVISOR - 1);
    localparam logic [CntW-1:0] CntPre  = CntW'(DIVISOR - 2);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == CntLast)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick     = !i_clear && (r_cnt == CntLast);
    assign o_pre_tick = !i_clear && (r_cnt == CntPre);

endmodule

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
//   Serial UART transmitter: start bit, DATA_BITS data bits LSB first,
//   optional parity, STOP_BITS stop bits. All outputs are registered.
//   Parameters: DIVISOR (clk per bit, >=2), DATA_BITS (5..8),
//               PARITY (PAR_NONE/PAR_ODD/PAR_EVEN), STOP_BITS (1 or 2)
//   Ports:
//     clk          in  system clock, rising edge
//     resetn       in  asynchronous, active-high reset
//     i_tx_data    in  byte to send, sampled on the accept edge only
//     i_tx_enable  in  request, accepted on an edge where o_tx_ready is high
//     o_tx_ready   out idle, able to accept a byte
//     o_tx_done    out one-cycle pulse on the last cycle of the final stop bit
//     o_tx         out serial line, idle high
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR   = 54,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_enable,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx
);

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    uart_state_e r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_parity;
    logic        r_tx_ready;
    logic        r_tx_done;
    logic        r_tx;

    logic w_clear;
    logic w_tick;
    logic w_pre_tick;
    logic w_par_in;

    // Timer is held at zero while idle, so the start bit is a full period
    // measured from the accept edge.
    assign w_clear  = (r_state == S_IDLE);
    assign w_par_in = parity_bit(i_tx_data, DATA_BITS, PARITY);

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk        (clk),
        .resetn     (resetn),
        .i_clear    (w_clear),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_tx_enable) begin
                        r_shift    <= i_tx_data;
                        r_parity   <= w_par_in;
                        r_bit_cnt  <= '0;
                        r_tx_ready <= 1'b0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LastData) begin
                            r_bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            // Next bit is shift[1]; present it as the shift lands.
                            r_tx      <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_pre_tick && (r_bit_cnt == LastStop)) begin
                        r_tx_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_bit_cnt == LastStop) begin
                            // A request still pending at frame end is taken on this
                            // edge, so the next start bit abuts the stop bit with no
                            // idle cycle; tx_ready then stays low across the seam.
                            if (i_tx_enable) begin
                                r_shift    <= i_tx_data;
                                r_parity   <= w_par_in;
                                r_bit_cnt  <= '0;
                                r_tx       <= 1'b0;
                                r_state    <= S_START;
                            end else begin
                                r_bit_cnt  <= '0;
                                r_tx_ready <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_tx_done  = r_tx_done;
    assign o_tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Directed bench. Five transmitter instances share clock, reset and data:
//     0: 8N1 /4   1: 8E1 /4   2: 8O1 /4   3: 7N2 /4   4: 8N1 /54
//   Expected frames are hand-computed bit vectors, bit 0 = start bit.
//   Each cycle of a frame compares {tx, tx_ready, tx_done} at the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       clk;
    logic       resetn;
    logic [7:0] tx_data;
    logic       en       [5];
    logic       tx_w     [5];
    logic       ready_w  [5];
    logic       done_w   [5];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_serializer #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .resetn(resetn), .i_tx_data(tx_data), .i_tx_enable(en[0]),
        .o_tx_ready(ready_w[0]), .o_tx_done(done_w[0]), .o_tx(tx_w[0])
    );
    uart_tx_serializer #(.DIVISOR(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .resetn(resetn), .i_tx_data(tx_data), .i_tx_enable(en[1]),
        .o_tx_ready(ready_w[1]), .o_tx_done(done_w[1]), .o_tx(tx_w[1])
    );
    uart_tx_serializer #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .resetn(resetn), .i_tx_data(tx_data), .i_tx_enable(en[2]),
        .o_tx_ready(ready_w[2]), .o_tx_done(done_w[2]), .o_tx(tx_w[2])
    );
    uart_tx_serializer #(.DIVISOR(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .resetn(resetn), .i_tx_data(tx_data), .i_tx_enable(en[3]),
        .o_tx_ready(ready_w[3]), .o_tx_done(done_w[3]), .o_tx(tx_w[3])
    );
    uart_tx_serializer #(.DIVISOR(54), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1_54 (
        .clk(clk), .resetn(resetn), .i_tx_data(tx_data), .i_tx_enable(en[4]),
        .o_tx_ready(ready_w[4]), .o_tx_done(done_w[4]), .o_tx(tx_w[4])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {tx, ready, done}
    function automatic logic [15:0] pins(input int idx);
        return {13'd0, tx_w[idx], ready_w[idx], done_w[idx]};
    endfunction

    task automatic expect_idle(input int idx, input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, i), pins(idx), 16'h0006);
        end
    endtask

    // Request one byte; enable drops and data changes right after the accept edge.
    task automatic start_tx(input int idx, input logic [7:0] data);
        @(negedge clk);
        tx_data = data;
        en[idx] = 1'b1;
        check("pre_accept_ready", {15'd0, ready_w[idx]}, 16'h0001);
        @(posedge clk);
        #1;
        en[idx] = 1'b0;
        tx_data = ~data;
    endtask

    // pulse_at: cycle at which a stray 0x3C request is raised for one edge.
    // abort_at: number of cycles to check before returning early (-1 = whole frame).
    task automatic expect_frame(input int idx, input string tag, input logic [15:0] exp,
                                input int nbits, input int div, input int pulse_at,
                                input int abort_at);
        int  n;
        logic d;
        n = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                if (abort_at >= 0 && n == abort_at) return;
                @(negedge clk);
                d = (b == nbits - 1) && (c == div - 1);
                check($sformatf("%s b%0d c%0d", tag, b, c), pins(idx),
                      {13'd0, exp[b], 1'b0, d});
                if (n == pulse_at) begin
                    en[idx] = 1'b1;
                    tx_data = 8'h3C;
                end else if (pulse_at >= 0 && n == pulse_at + 1) begin
                    en[idx] = 1'b0;
                    tx_data = 8'h00;
                end
                n++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        tx_data = 8'h00;
        for (int i = 0; i < 5; i++) en[i] = 1'b0;
        resetn  = 1'b0;
        #2;
        resetn  = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) check($sformatf("reset_state u%0d", i), pins(i), 16'h0006);
        @(negedge clk);
        resetn = 1'b0;
        expect_idle(0, "post_reset", 2);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        start_tx(0, 8'hA5);
        expect_frame(0, "8n1_a5", 16'h034A, 10, 4, -1, -1);
        expect_idle(0, "8n1_a5_end", 2);

        // 8E1 / 8O1 0xA5 (four ones): parity 0 / 1
        start_tx(1, 8'hA5);
        expect_frame(1, "8e1_a5", 16'h054A, 11, 4, -1, -1);
        expect_idle(1, "8e1_end", 2);
        start_tx(2, 8'hA5);
        expect_frame(2, "8o1_a5", 16'h074A, 11, 4, -1, -1);
        expect_idle(2, "8o1_end", 2);

        // Back-to-back 0x00 then 0xFF with enable held
        @(negedge clk);
        tx_data = 8'h00;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        expect_frame(0, "b2b_00", 16'h0200, 10, 4, -1, -1);
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        expect_frame(0, "b2b_ff", 16'h03FE, 10, 4, -1, -1);
        expect_idle(0, "b2b_end", 2);

        // Stray request for 0x3C during a 0x55 frame is dropped
        start_tx(0, 8'h55);
        expect_frame(0, "ign_55", 16'h02AA, 10, 4, 9, -1);
        expect_idle(0, "ign_end", 6);

        // Reset during data bit 3, then a clean 0x81 frame
        start_tx(0, 8'hA5);
        expect_frame(0, "rst_a5", 16'h034A, 10, 4, -1, 18);
        resetn = 1'b1;
        #1;
        check("rst_async", pins(0), 16'h0006);
        @(negedge clk);
        check("rst_held", pins(0), 16'h0006);
        resetn = 1'b0;
        expect_idle(0, "rst_idle", 3);
        start_tx(0, 8'h81);
        expect_frame(0, "rst_81", 16'h0302, 10, 4, -1, -1);
        expect_idle(0, "rst_81_end", 2);

        // 7N2: 0x7F, and 0xFF whose bit 7 must be ignored
        start_tx(3, 8'h7F);
        expect_frame(3, "7n2_7f", 16'h03FE, 10, 4, -1, -1);
        expect_idle(3, "7n2_7f_end", 2);
        start_tx(3, 8'hFF);
        expect_frame(3, "7n2_ff", 16'h03FE, 10, 4, -1, -1);
        expect_idle(3, "7n2_ff_end", 2);

        // Full-rate divisor
        start_tx(4, 8'hA5);
        expect_frame(4, "d54_a5", 16'h034A, 10, 54, -1, -1);
        expect_idle(4, "d54_end", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
